// File: rtl/ram16k_pkg.sv
// Shared widths, word/address types and bank decode helpers for the 16K x 16 data memory.
package ram16k_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 14;
    localparam int BANK_ADDR_W = 12;
    localparam int NUM_BANKS   = 4;
    localparam int BANK_SEL_W  = ADDR_W - BANK_ADDR_W;
    localparam int BANK_DEPTH  = 1 << BANK_ADDR_W;

    typedef logic [DATA_W-1:0]      word_t;
    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [BANK_ADDR_W-1:0] bank_addr_t;
    typedef logic [BANK_SEL_W-1:0]  bank_sel_t;

    function automatic bank_sel_t bank_of(input addr_t a);
        return a[ADDR_W-1:BANK_ADDR_W];
    endfunction

    function automatic bank_addr_t offset_of(input addr_t a);
        return a[BANK_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/ram_4k.sv
// 4096 x 16 bank: combinational read, synchronous write, reset clears via a per-word valid bitmap.
// Optional RAM16K_WRITE_THROUGH_EN: while load=1 the bank output shows the write data.
module ram_4k
    import ram16k_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [DATA_W-1:0]      out,
    input  logic [DATA_W-1:0]      in,
    input  logic [BANK_ADDR_W-1:0] address,
    input  logic                   load
);

    word_t                 mem [BANK_DEPTH];
    logic [BANK_DEPTH-1:0] valid;
    word_t                 stored;

    // Storage carries no reset so it can map onto a plain RAM; the valid bitmap masks stale data.
    always_ff @(posedge clk) begin
        if (rst_n && load) begin
            mem[address] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (load) begin
            valid[address] <= 1'b1;
        end
    end

    always_comb begin
        stored = '0;
        if (rst_n && valid[address]) begin
            stored = mem[address];
        end
    end

`ifdef RAM16K_WRITE_THROUGH_EN
    assign out = (rst_n && load) ? in : stored;
`else
    assign out = stored;
`endif

endmodule

// File: rtl/ram_16k.sv
// 16K x 16 data memory built from four 4K banks; address[13:12] selects the bank.
// Optional RAM16K_WRITE_THROUGH_EN is honoured inside each bank (the selected bank sees load).
module ram_16k
    import ram16k_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load
);

    bank_sel_t              sel;
    bank_addr_t             offset;
    logic [NUM_BANKS-1:0]   bank_load;
    word_t                  bank_out [NUM_BANKS];

    assign sel    = bank_of(address);
    assign offset = offset_of(address);

    always_comb begin
        bank_load = '0;
        bank_load[sel] = load;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_4k u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .out     (bank_out[b]),
            .in      (in),
            .address (offset),
            .load    (bank_load[b])
        );
    end

    assign out = bank_out[sel];

endmodule

// File: tb/tb_ram_16k.sv
// Directed self-checking bench for ram_16k: reset, write/read, bank boundaries, read-during-write, async reset.
module tb_ram_16k;

    logic        clk;
    logic        rst_n;
    logic [15:0] out;
    logic [15:0] in;
    logic [13:0] address;
    logic        load;

    int checks = 0;
    int errors = 0;

    ram_16k dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .out     (out),
        .in      (in),
        .address (address),
        .load    (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writes are set up on the falling edge and committed on the following rising edge.
    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clk);
        address = a[13:0];
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [15:0] v);
        address = a[13:0];
        #1;
        v = out;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        int addrs [4] = '{0, 4095, 4096, 16383};
        rst_n = 1'b0;
        load  = 1'b0;
        in    = 16'h0;
        address = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: out=%h expected 0000", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        foreach (addrs[i]) begin
            read_word(addrs[i], v);
            checks++;
            if (v !== 16'h0) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d: out=%h expected 0000", addrs[i], v);
            end
        end
    endtask

    task automatic test_single_write;
        logic [15:0] v;
        write_word(5, 16'd123);
        read_word(5, v);
        checks++;
        if (v !== 16'd123) begin
            errors++;
            $display("FAIL single_write addr=5: out=%0d expected 123", v);
        end
        read_word(4, v);
        checks++;
        if (v !== 16'd0) begin
            errors++;
            $display("FAIL single_neighbour addr=4: out=%0d expected 0", v);
        end
        read_word(6, v);
        checks++;
        if (v !== 16'd0) begin
            errors++;
            $display("FAIL single_neighbour addr=6: out=%0d expected 0", v);
        end
    endtask

    task automatic test_bank_boundaries;
        logic [15:0] v;
        int          a_tab [7] = '{4095, 4096, 12288, 16383, 0, 12287, 8191};
        logic [15:0] e_tab [7] = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        write_word(4095,  16'h1111);
        write_word(4096,  16'h2222);
        write_word(12288, 16'h3333);
        write_word(16383, 16'hFFFF);
        @(negedge clk);
        foreach (a_tab[i]) begin
            read_word(a_tab[i], v);
            checks++;
            if (v !== e_tab[i]) begin
                errors++;
                $display("FAIL bank_boundary addr=%0d: out=%h expected %h", a_tab[i], v, e_tab[i]);
            end
        end
    endtask

    task automatic test_read_during_write;
        logic [15:0] exp_before;
        write_word(7, 16'd246);
`ifdef RAM16K_WRITE_THROUGH_EN
        exp_before = 16'd369;
`else
        exp_before = 16'd246;
`endif
        @(negedge clk);
        address = 14'd7;
        in      = 16'd369;
        load    = 1'b1;
        #1;
        checks++;
        if (out !== exp_before) begin
            errors++;
            $display("FAIL rdw_before_edge: out=%0d expected %0d", out, exp_before);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'd369) begin
            errors++;
            $display("FAIL rdw_after_edge: out=%0d expected 369", out);
        end
        load = 1'b0;
        #1;
        checks++;
        if (out !== 16'd369) begin
            errors++;
            $display("FAIL rdw_after_load_drop: out=%0d expected 369", out);
        end
    endtask

    task automatic test_load_low;
        logic [15:0] v;
        @(negedge clk);
        load    = 1'b0;
        in      = 16'hABCD;
        address = 14'd7;
        repeat (3) @(posedge clk);
        #1;
        read_word(7, v);
        checks++;
        if (v !== 16'd369) begin
            errors++;
            $display("FAIL load_low addr=7: out=%0d expected 369", v);
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] v;
        for (int a = 0; a < 32; a++) begin
            write_word(a, 16'(a * 123));
        end
        @(negedge clk);
        read_word(31, v);
        checks++;
        if (v !== 16'd3813) begin
            errors++;
            $display("FAIL fill_check addr=31: out=%0d expected 3813", v);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%h expected 0000", out);
        end
        // A write attempted while reset is held must be dropped.
        address = 14'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_word(a, v);
            checks++;
            if (v !== 16'h0) begin
                errors++;
                $display("FAIL async_reset_cleared addr=%0d: out=%h expected 0000", a, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bank_boundaries();
        test_read_during_write();
        test_load_low();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
